// File: rtl/pool_stream_if.sv
// Valid/ready beat bus carrying CH packed W-bit pixels.
// The upstream side has no frame marker, so only the downstream modport exposes last.
interface pool_stream_if #(
  parameter int CH = 18,
  parameter int W  = 1
);
  logic          valid;
  logic          ready;
  logic [CH*W-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pool_stream.sv
// Streaming POOLxPOOL max/average pooling over raster-order pixels, all CH channels per beat.
// A line buffer of IN_W/POOL accumulators holds partial windows; one pooled beat leaves per window.
module pool_stream #(
  parameter int CH   = 18,
  parameter int W    = 1,
  parameter int IN_H = 24,
  parameter int IN_W = 24,
  parameter int POOL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_i,
  output logic             busy_o,
  pool_stream_if.slave     in_if,
  pool_stream_if.master    out_if
);
  localparam int LP  = $clog2(POOL);
  localparam int SH  = 2 * LP;
  localparam int A   = W + SH;
  localparam int NOC = IN_W / POOL;
  localparam int RW  = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int CW  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int OW  = (NOC > 1) ? $clog2(NOC) : 1;

  function automatic logic [A-1:0] comb_fn(input logic avg, input logic [A-1:0] acc,
                                           input logic [W-1:0] pix);
    logic [A-1:0] p;
    p = A'(pix);
    if (avg) return acc + p;
    return (p > acc) ? p : acc;
  endfunction

  // Average is floor division by POOL*POOL; max already fits in W bits.
  function automatic logic [W-1:0] fin_fn(input logic avg, input logic [A-1:0] acc);
    logic [A-1:0] s;
    s = acc >> SH;
    if (avg) return s[W-1:0];
    return acc[W-1:0];
  endfunction

  logic [RW-1:0]   r_q, r_d;
  logic [CW-1:0]   c_q, c_d;
  logic            mode_q, mode_d;
  logic            busy_q, busy_d;
  logic            ov_q, ov_d;
  logic            last_q, last_d;
  logic [CH*W-1:0] od_q, od_d;
  logic [CH*A-1:0] lb_q [NOC];
  logic [CH*A-1:0] acc_nxt;
  logic [CH*W-1:0] fin;
  logic [OW-1:0]   oc;
  logic            acc, first, lastpix, win_start, win_end, avg;

  assign in_if.ready  = !ov_q || out_if.ready;
  assign acc          = in_if.valid && in_if.ready;
  assign first        = (r_q == '0) && (c_q == '0);
  assign lastpix      = (r_q == RW'(IN_H - 1)) && (c_q == CW'(IN_W - 1));
  assign win_start    = (r_q[LP-1:0] == '0) && (c_q[LP-1:0] == '0);
  assign win_end      = (&r_q[LP-1:0]) && (&c_q[LP-1:0]);
  // The opening beat of a frame already obeys the incoming mode.
  assign avg          = first ? mode_i : mode_q;
  assign oc           = OW'(c_q >> LP);

  assign out_if.valid = ov_q;
  assign out_if.data  = od_q;
  assign out_if.last  = last_q;
  assign busy_o       = busy_q;

  always_comb begin
    acc_nxt = '0;
    fin     = '0;
    for (int k = 0; k < CH; k++) begin
      acc_nxt[k*A +: A] = win_start ? A'(in_if.data[k*W +: W])
                                    : comb_fn(avg, lb_q[oc][k*A +: A], in_if.data[k*W +: W]);
      fin[k*W +: W]     = fin_fn(avg, acc_nxt[k*A +: A]);
    end
  end

  always_comb begin
    r_d    = r_q;
    c_d    = c_q;
    mode_d = mode_q;
    busy_d = busy_q;
    ov_d   = ov_q && !out_if.ready;
    last_d = last_q && ov_d;
    od_d   = od_q;
    if (acc) begin
      if (c_q == CW'(IN_W - 1)) begin
        c_d = '0;
        r_d = (r_q == RW'(IN_H - 1)) ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
      if (first) mode_d = mode_i;
      if (lastpix) busy_d = 1'b0;
      if (first) busy_d = 1'b1;
      if (win_end) begin
        ov_d   = 1'b1;
        od_d   = fin;
        last_d = lastpix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      c_q    <= '0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      ov_q   <= 1'b0;
      last_q <= 1'b0;
      od_q   <= '0;
    end else begin
      r_q    <= r_d;
      c_q    <= c_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
      ov_q   <= ov_d;
      last_q <= last_d;
      od_q   <= od_d;
    end
  end

  // Window accumulators: contents are meaningless after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (acc) lb_q[oc] <= acc_nxt;
  end
endmodule

// File: doc/pool_stream.md
Name: pool_stream

Overview:
- Parametrised streaming pooling stage for the CNN datapath. It replaces the fixed 18-channel, 24x24 to 12x12 combinational pool wrappers.
- It accepts one pixel position per beat in raster order, carrying all CH channels in parallel. It emits one pooled pixel per POOLxPOOL window, again with all CH channels.
- It supports max or average mode over unsigned W-bit pixels. With W=1 in max mode it reproduces the binary OR-pooling of the existing layers.
- It sits between a conv stage and the next conv stage, with valid/ready on both sides.

Parameters:
- CH, 18, channels processed in parallel.
- W, 1, bits per pixel per channel (unsigned).
- IN_H, 24, input map height.
- IN_W, 24, input map width.
- POOL, 2, window size and stride. Must be a power of two ≥2. IN_H and IN_W must be multiples of POOL.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = max, 1 = average. Sampled at the first accepted beat of each frame.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  CH*W  pixel vector. Channel k occupies bits [k*W +: W].
- out_valid  out  1  pooled beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  CH*W  pooled pixel vector, same packing as in_data.
- out_last  out  1  qualifies the final pooled beat of a frame.
- busy  out  1  high from the first accepted beat of a frame until its last input beat is accepted.

Behaviour:
- Reset (rst=1 at a clk edge) clears all state:
  - row and column counters to 0.
  - out_valid, out_data, out_last and busy to 0.
  - Latched mode to 0.
  - Line-buffer contents are don't-care.
- Reset mid-frame discards the partial frame; the next accepted beat is pixel (0,0).
- in_ready = !out_valid || out_ready, combinational. It does not depend on in_valid.
- Counters r in 0..IN_H-1 and c in 0..IN_W-1 advance only on an accepted input beat.
  - c wraps to 0 after IN_W-1 and increments r.
  - r wraps to 0 after IN_H-1, which ends the frame.
- Frames run back-to-back with no idle cycle required.
- Line buffer: IN_W/POOL entries, indexed oc = c/POOL. Each entry holds CH accumulators of A = W + 2*log2(POOL) bits.
  - Window start (r%POOL==0 and c%POOL==0): entry[oc] is loaded with the zero-extended pixel.
  - Otherwise: entry[oc] = combine(entry[oc], pixel). In max mode, combine is the per-channel unsigned max. In average mode, it is the per-channel sum; A bits are sufficient, so there is no overflow.
- Window end (r%POOL==POOL-1 and c%POOL==POOL-1): the finished value is registered into out_data on the same edge that accepts the beat, and out_valid is set.
  - In max mode, out_data takes the low W bits of the max.
  - In average mode, out_data = sum >> (2*log2(POOL)), i.e. floor.
  - The line-buffer write for that entry is a don't-care.
- Latency: one cycle from acceptance of the window-closing beat to out_valid=1.
- out_valid holds, with out_data and out_last stable, until out_valid && out_ready.
- Acceptance while out_valid && out_ready with a new window end: out_valid stays 1 and new data loads. There is no bubble.
- out_last = 1 only with the pooled beat produced by input (IN_H-1, IN_W-1).
- Mode is latched on the accepted beat at (0,0), and that beat uses the incoming mode. Changes to mode mid-frame have no effect until the next frame.
- busy:
  - Set on the accepted (0,0) beat.
  - Cleared on the accepted (IN_H-1, IN_W-1) beat.
  - If both occur on one beat (a 1x1 frame is not permitted since POOL≥2), set takes priority.
- Output count per frame is exactly (IN_H/POOL)*(IN_W/POOL), in raster order of output coordinates.

Test Plan:
- Binary OR pooling. CH=1, W=1, IN_H=IN_W=4, mode=0. Input rows 1000/0000/0001/0010. Required outputs in order: 1,0,0,1. out_last is set on the 4th output.
- Average pooling. CH=2, W=8, 4x4 frame, mode=1, window 0 ch0 = {10,11,12,14}. Required ch0 output = 11 (floor of 47/4). A window of all 255 gives 255, checking accumulator width.
- Backpressure. Hold out_ready=0 after the first pooled beat. Required: in_ready=0, input counters frozen, out_data stable. Release out_ready; the streams resume with no lost or duplicated beats.
- Back-to-back frames. Stream two 24x24 frames continuously with out_ready=1, default parameters. Required: 144 outputs per frame, out_last exactly on outputs #144 and #288, and results match a reference per-channel OR of 2x2 windows.
- Mid-frame events.
  - Toggle mode mid-frame: the current frame's results are unaffected, and the next frame uses the new mode.
  - Assert rst for one cycle after 37 beats: out_valid=0 and busy=0 the following cycle. The next beat is treated as (0,0), and the full frame produces correct results.
